// File: rtl/hit_pattern_gen_pkg.sv
// Shared types and helpers for the hit pattern generator: FSM encoding,
// LFSR constants and the round-robin channel search.
package hpg_pkg;

    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    localparam int PTR_W  = 4;
    localparam int MAX_CH = 16;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HIGH   = 2'd1;
    localparam logic [1:0] S_LOW    = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = S_IDLE,
        HIGH   = S_HIGH,
        LOW    = S_LOW,
        FINISH = S_FINISH
    } state_e;

    // First set bit strictly after ptr, searching upward and wrapping at n_ch.
    // Passing ptr = n_ch-1 yields the lowest set bit. Returns ptr if none found.
    function automatic logic [PTR_W-1:0] next_set_bit(
        input logic [MAX_CH-1:0] mask,
        input logic [PTR_W-1:0]  ptr,
        input int unsigned       n_ch
    );
        logic [PTR_W-1:0] result;
        logic             found;
        logic [PTR_W:0]   idx;
        logic [PTR_W:0]   n_w;
        result = ptr;
        found  = 1'b0;
        n_w    = (PTR_W+1)'(n_ch);
        for (int unsigned i = 1; i <= MAX_CH; i++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx >= n_w) begin
                idx = idx - n_w;
            end
            if (!found && (i <= n_ch) && mask[idx[PTR_W-1:0]]) begin
                result = idx[PTR_W-1:0];
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hit_pattern_gen_if.sv
// Control/config/status bundle between a test controller (master) and the
// hit pattern generator (slave).
interface hit_pattern_gen_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int WID_W = 8
) ();

    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_count;
    logic [WID_W-1:0] cfg_high;
    logic [WID_W-1:0] cfg_low;
    logic             cfg_jit_en;
    logic [N_CH-1:0]  cfg_ch_mask;
    logic             cfg_mode;

    logic [N_CH-1:0]  hit_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hits_sent;

    modport master (
        output start, abort, cfg_count, cfg_high, cfg_low,
               cfg_jit_en, cfg_ch_mask, cfg_mode,
        input  hit_out, busy, done, hits_sent
    );

    modport slave (
        input  start, abort, cfg_count, cfg_high, cfg_low,
               cfg_jit_en, cfg_ch_mask, cfg_mode,
        output hit_out, busy, done, hits_sent
    );

endinterface

// File: rtl/hit_pattern_gen_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that advances only when enabled,
// so a given seed always replays the same sequence.
module lfsr16
    import hpg_pkg::*;
#(
    parameter logic [15:0] SEED  = DEFAULT_SEED,
    parameter int          OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [OUT_W-1:0] state
);

    // An all-zero state would lock the register up.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] lfsr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= SEED_EFF;
        end else if (enable) begin
            lfsr_reg <= lfsr_reg[0] ? ((lfsr_reg >> 1) ^ LFSR_POLY) : (lfsr_reg >> 1);
        end
    end

    assign state = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/hit_pattern_gen.sv
// Programmable hit pulse train generator for TDC self-test: broadcast or
// round-robin pulses with configurable high/low widths and LFSR jitter.
module hit_pattern_gen
    import hpg_pkg::*;
#(
    parameter int          N_CH      = 4,
    parameter int          CNT_W     = 16,
    parameter int          WID_W     = 8,
    parameter int          JIT_W     = 6,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    hit_pattern_gen_if.slave   bus
);

    // One extra bit so base high width plus jitter cannot overflow.
    localparam int DUR_W = WID_W + 1;

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WID_W-1:0] high_reg, high_next;
    logic [WID_W-1:0] low_reg, low_next;
    logic             jit_en_reg, jit_en_next;
    logic [N_CH-1:0]  mask_reg, mask_next;
    logic             mode_reg, mode_next;
    logic [DUR_W-1:0] dur_reg, dur_next;
    logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [N_CH-1:0]  hit_out_reg, hit_out_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [CNT_W-1:0] hits_sent_reg, hits_sent_next;

    logic [JIT_W-1:0] lfsr_bits;

    lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (JIT_W)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (busy_reg),
        .state  (lfsr_bits)
    );

    // A HIGH entry takes its operands from the cfg bus on an accepted start
    // and from the shadow registers for every later pulse.
    logic              accept;
    logic [WID_W-1:0]  sel_high;
    logic              sel_jit_en;
    logic [N_CH-1:0]   sel_mask;
    logic [MAX_CH-1:0] mask_ext;
    logic [PTR_W-1:0]  first_ptr;
    logic [PTR_W-1:0]  adv_ptr;
    logic [N_CH-1:0]   onehot_first;
    logic [N_CH-1:0]   onehot_cur;
    logic [DUR_W-1:0]  jit_add;
    logic [DUR_W-1:0]  high_load;
    logic [DUR_W-1:0]  low_load;

    assign accept     = (state_reg == IDLE) && bus.start && !bus.abort;
    assign sel_high   = accept ? bus.cfg_high    : high_reg;
    assign sel_jit_en = accept ? bus.cfg_jit_en  : jit_en_reg;
    assign sel_mask   = accept ? bus.cfg_ch_mask : mask_reg;

    always_comb begin
        mask_ext = '0;
        mask_ext[N_CH-1:0] = sel_mask;
    end

    assign first_ptr = next_set_bit(mask_ext, PTR_W'(N_CH - 1), N_CH);
    assign adv_ptr   = next_set_bit(mask_ext, rr_ptr_reg, N_CH);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_onehot
            assign onehot_first[gi] = (first_ptr == PTR_W'(gi));
            assign onehot_cur[gi]   = (rr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Counters are loaded with duration-1 and the state exits on zero.
    assign jit_add   = sel_jit_en ? DUR_W'(lfsr_bits) : '0;
    assign high_load = ((sel_high == '0) ? '0 : DUR_W'(sel_high) - DUR_W'(1)) + jit_add;
    assign low_load  = (low_reg == '0) ? '0 : DUR_W'(low_reg) - DUR_W'(1);

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        high_next      = high_reg;
        low_next       = low_reg;
        jit_en_next    = jit_en_reg;
        mask_next      = mask_reg;
        mode_next      = mode_reg;
        dur_next       = dur_reg;
        rr_ptr_next    = rr_ptr_reg;
        hit_out_next   = hit_out_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        hits_sent_next = hits_sent_reg;

        if (bus.abort) begin
            state_next   = IDLE;
            hit_out_next = '0;
            busy_next    = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        count_next     = bus.cfg_count;
                        high_next      = bus.cfg_high;
                        low_next       = bus.cfg_low;
                        jit_en_next    = bus.cfg_jit_en;
                        mask_next      = bus.cfg_ch_mask;
                        mode_next      = bus.cfg_mode;
                        hits_sent_next = '0;
                        if ((bus.cfg_count != '0) && (bus.cfg_ch_mask != '0)) begin
                            state_next   = HIGH;
                            busy_next    = 1'b1;
                            rr_ptr_next  = first_ptr;
                            dur_next     = high_load;
                            hit_out_next = bus.cfg_mode ? onehot_first : bus.cfg_ch_mask;
                        end else begin
                            state_next = FINISH;
                            done_next  = 1'b1;
                        end
                    end
                end

                HIGH: begin
                    if (dur_reg == '0) begin
                        state_next     = LOW;
                        hit_out_next   = '0;
                        hits_sent_next = hits_sent_reg + CNT_W'(1);
                        dur_next       = low_load;
                        rr_ptr_next    = adv_ptr;
                    end else begin
                        dur_next = dur_reg - DUR_W'(1);
                    end
                end

                LOW: begin
                    if (dur_reg == '0) begin
                        if (hits_sent_reg == count_reg) begin
                            state_next = FINISH;
                            done_next  = 1'b1;
                            busy_next  = 1'b0;
                        end else begin
                            state_next   = HIGH;
                            dur_next     = high_load;
                            hit_out_next = mode_reg ? onehot_cur : mask_reg;
                        end
                    end else begin
                        dur_next = dur_reg - DUR_W'(1);
                    end
                end

                FINISH: begin
                    state_next = IDLE;
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            high_reg      <= '0;
            low_reg       <= '0;
            jit_en_reg    <= 1'b0;
            mask_reg      <= '0;
            mode_reg      <= 1'b0;
            dur_reg       <= '0;
            rr_ptr_reg    <= '0;
            hit_out_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            hits_sent_reg <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            high_reg      <= high_next;
            low_reg       <= low_next;
            jit_en_reg    <= jit_en_next;
            mask_reg      <= mask_next;
            mode_reg      <= mode_next;
            dur_reg       <= dur_next;
            rr_ptr_reg    <= rr_ptr_next;
            hit_out_reg   <= hit_out_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            hits_sent_reg <= hits_sent_next;
        end
    end

    assign bus.hit_out   = hit_out_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.hits_sent = hits_sent_reg;

endmodule

// File: tb/tb_hit_pattern_gen.sv
// Randomized self-checking bench for hit_pattern_gen against a pulse-list
// reference model (expected per-cycle waveform built from the train rules).
module tb_hit_pattern_gen;

    localparam int          N_CH  = 4;
    localparam int          CNT_W = 16;
    localparam int          WID_W = 8;
    localparam int          JIT_W = 6;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_lfsr;
    int          obs_widths[$];

    hit_pattern_gen_if #(.N_CH(N_CH), .CNT_W(CNT_W), .WID_W(WID_W)) bus ();

    hit_pattern_gen #(
        .N_CH      (N_CH),
        .CNT_W     (CNT_W),
        .WID_W     (WID_W),
        .JIT_W     (JIT_W),
        .LFSR_SEED (SEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic drive_idle();
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.cfg_count   = '0;
        bus.cfg_high    = '0;
        bus.cfg_low     = '0;
        bus.cfg_jit_en  = 1'b0;
        bus.cfg_ch_mask = '0;
        bus.cfg_mode    = 1'b0;
    endtask

    task automatic scramble_cfg();
        bus.cfg_count   = CNT_W'($urandom);
        bus.cfg_high    = WID_W'($urandom);
        bus.cfg_low     = WID_W'($urandom);
        bus.cfg_jit_en  = 1'($urandom);
        bus.cfg_ch_mask = N_CH'($urandom);
        bus.cfg_mode    = 1'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_lfsr = SEED;
        @(posedge clk);
        #1;
    endtask

    // Builds the expected waveform, starts a train in the current (idle) cycle,
    // and compares every cycle through the done pulse and one idle cycle after.
    task automatic run_train(input int count, input int high, input int low,
                             input bit jit_en, input logic [N_CH-1:0] mask,
                             input bit mode, input string name);
        logic [N_CH-1:0] exp_hit[$];
        int              exp_hs[$];
        int              chans[$];
        int              n_pulses, hw, lw, t, total, run_len, exp_hs_c;
        logic [15:0]     lv;
        logic [N_CH-1:0] pat, exp_h;
        logic            exp_busy, exp_done;
        bit              ok;

        for (int i = 0; i < N_CH; i++) if (mask[i]) chans.push_back(i);
        n_pulses = (count == 0 || mask == '0) ? 0 : count;
        lv = model_lfsr;
        t  = 0;
        for (int k = 0; k < n_pulses; k++) begin
            // Jitter comes from the LFSR value seen in the cycle just before the pulse.
            hw = ((high == 0) ? 1 : high) + (jit_en ? int'(lv[JIT_W-1:0]) : 0);
            lw = (low == 0) ? 1 : low;
            if (mode) begin
                pat = '0;
                pat[chans[k % chans.size()]] = 1'b1;
            end else begin
                pat = mask;
            end
            for (int c = 0; c < hw + lw; c++) begin
                if (t > 0) lv = lfsr_step(lv);
                t++;
                exp_hit.push_back((c < hw) ? pat : '0);
                exp_hs.push_back((c < hw) ? k : k + 1);
            end
        end
        total = t;
        model_lfsr = (total == 0) ? lv : lfsr_step(lv);

        bus.cfg_count   = CNT_W'(count);
        bus.cfg_high    = WID_W'(high);
        bus.cfg_low     = WID_W'(low);
        bus.cfg_jit_en  = jit_en;
        bus.cfg_ch_mask = mask;
        bus.cfg_mode    = mode;
        bus.start       = 1'b1;

        ok = 1'b1;
        run_len = 0;
        obs_widths.delete();
        for (int c = 0; c <= total + 1; c++) begin
            @(posedge clk);
            #1;
            exp_h    = (c < total) ? exp_hit[c] : '0;
            exp_busy = (c < total);
            exp_done = (c == total);
            exp_hs_c = (c < total) ? exp_hs[c] : n_pulses;
            if (ok) begin
                checks++;
                if (bus.hit_out !== exp_h || bus.busy !== exp_busy ||
                    bus.done !== exp_done || bus.hits_sent !== CNT_W'(exp_hs_c)) begin
                    errors++;
                    ok = 1'b0;
                    $display("FAIL %s cycle %0d: got hit_out=%b busy=%b done=%b hits_sent=%0d, want hit_out=%b busy=%b done=%b hits_sent=%0d",
                             name, c, bus.hit_out, bus.busy, bus.done, bus.hits_sent,
                             exp_h, exp_busy, exp_done, exp_hs_c);
                end
            end
            if (bus.hit_out != '0) begin
                run_len++;
            end else if (run_len > 0) begin
                obs_widths.push_back(run_len);
                run_len = 0;
            end
            // Config churn and stray starts mid-train must have no effect.
            if (c <= total) begin
                bus.start = 1'($urandom_range(0, 1));
                scramble_cfg();
            end else begin
                bus.start = 1'b0;
            end
        end
        $display("train %s: count=%0d high=%0d low=%0d jit=%0d mask=%b mode=%0d pulses=%0d cycles=%0d %s",
                 name, count, high, low, jit_en, mask, mode, n_pulses, total, ok ? "ok" : "bad");
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.hit_out !== '0) begin errors++; $display("FAIL reset_hit_out: got %b want 0", bus.hit_out); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++;
        if (bus.hits_sent !== '0) begin errors++; $display("FAIL reset_hits_sent: got %0d want 0", bus.hits_sent); end
        $display("reset: outputs checked while rst_n low");
        @(negedge clk);
        rst_n = 1'b1;
        model_lfsr = SEED;
        @(posedge clk);
        #1;
    endtask

    task automatic test_broadcast();
        run_train(32, 20, 30, 1'b0, 4'b1111, 1'b0, "broadcast");
    endtask

    task automatic test_round_robin();
        run_train(6, 3, 2, 1'b0, 4'b1010, 1'b1, "rr_1010");
        run_train(3, 2, 2, 1'b0, 4'b0100, 1'b1, "rr_single");
        run_train(7, 1, 1, 1'b0, 4'b1101, 1'b1, "rr_1101");
    endtask

    task automatic test_degenerate();
        run_train(0, 5, 5, 1'b0, 4'b1111, 1'b0, "count_zero");
        run_train(4, 2, 2, 1'b0, 4'b0000, 1'b0, "mask_zero");
        run_train(3, 0, 0, 1'b0, 4'b1111, 1'b0, "high_low_zero");
    endtask

    task automatic test_back_to_back();
        run_train(2, 1, 1, 1'b0, 4'b0011, 1'b0, "b2b_first");
        run_train(3, 2, 1, 1'b0, 4'b1001, 1'b1, "b2b_second");
    endtask

    task automatic test_abort();
        bus.cfg_count   = CNT_W'(10);
        bus.cfg_high    = WID_W'(5);
        bus.cfg_low     = WID_W'(4);
        bus.cfg_jit_en  = 1'b0;
        bus.cfg_ch_mask = 4'b1111;
        bus.cfg_mode    = 1'b0;
        bus.start       = 1'b1;
        // Pulse 5 is high in cycles 36..40; abort lands in cycle 38.
        for (int c = 0; c <= 38; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        checks++;
        if (bus.hit_out !== 4'b1111 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got hit_out=%b busy=%b want 1111 1", bus.hit_out, bus.busy);
        end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.hit_out !== '0) begin errors++; $display("FAIL abort_hit_out: got %b want 0", bus.hit_out); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.hits_sent !== CNT_W'(4)) begin errors++; $display("FAIL abort_hits_sent: got %0d want 4", bus.hits_sent); end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hit_out !== '0) begin
                errors++;
                $display("FAIL abort_quiet cycle %0d: got done=%b busy=%b hit_out=%b want 0 0 0",
                         c, bus.done, bus.busy, bus.hit_out);
            end
            @(posedge clk);
            #1;
        end
        $display("abort: train stopped during pulse 5");
    endtask

    task automatic test_reset_mid_train();
        bus.cfg_count   = CNT_W'(5);
        bus.cfg_high    = WID_W'(10);
        bus.cfg_low     = WID_W'(10);
        bus.cfg_jit_en  = 1'b0;
        bus.cfg_ch_mask = 4'b0110;
        bus.cfg_mode    = 1'b0;
        bus.start       = 1'b1;
        for (int c = 0; c <= 22; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        checks++;
        if (bus.hit_out !== 4'b0110 || bus.hits_sent !== CNT_W'(1)) begin
            errors++;
            $display("FAIL rstmid_pre: got hit_out=%b hits_sent=%0d want 0110 1", bus.hit_out, bus.hits_sent);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.hit_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hits_sent !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got hit_out=%b busy=%b done=%b hits_sent=%0d want all 0",
                     bus.hit_out, bus.busy, bus.done, bus.hits_sent);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_lfsr = SEED;
        @(posedge clk);
        #1;
        $display("reset mid-train: outputs cleared asynchronously");
        run_train(4, 3, 2, 1'b0, 4'b0110, 1'b1, "after_reset");
    endtask

    task automatic test_jitter();
        int first_widths[$];
        do_reset();
        run_train(8, 20, 5, 1'b1, 4'b1111, 1'b0, "jitter_run1");
        checks++;
        if (obs_widths.size() != 8) begin
            errors++;
            $display("FAIL jitter_pulse_count: got %0d want 8", obs_widths.size());
        end
        foreach (obs_widths[i]) begin
            checks++;
            if (obs_widths[i] < 20 || obs_widths[i] > 83) begin
                errors++;
                $display("FAIL jitter_range pulse %0d: got width %0d want 20..83", i, obs_widths[i]);
            end
        end
        first_widths = obs_widths;
        do_reset();
        run_train(8, 20, 5, 1'b1, 4'b1111, 1'b0, "jitter_run2");
        checks++;
        if (obs_widths != first_widths) begin
            errors++;
            $display("FAIL jitter_repeat: second run widths differ (got %0d pulses, want %0d)",
                     obs_widths.size(), first_widths.size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_train($urandom_range(1, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                      1'($urandom_range(0, 1)), N_CH'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), $sformatf("random_%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_round_robin();
        test_degenerate();
        test_back_to_back();
        test_abort();
        test_reset_mid_train();
        test_jitter();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hit_pattern_gen.md
Name: hit_pattern_gen

Overview:
- Synthesizable on-chip hit stimulus generator for TDC self-test; successor to the bench-only hit stimulus, now in fabric.
- Emits a programmable train of hit pulses on N_CH channels, with configurable high and low widths and optional LFSR width jitter.
- Pulses go either to all enabled channels at once or round-robin across them.
- Sits ahead of the TDC hit inputs behind a mux; controlled alongside the write/read stage logic.

Parameters:
- N_CH, 4, number of hit output channels (1..16).
- CNT_W, 16, width of the pulse counter and of the hit count config.
- WID_W, 8, width of the high/low duration configs, in clock cycles.
- JIT_W, 6, number of LFSR bits used as extra high-width jitter (0..2^JIT_W-1 cycles).
- LFSR_SEED, 16'hACE1, LFSR reset value; 0 is illegal and is replaced by 16'hACE1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that starts a train; ignored while busy.
- abort  in  1  stops the train immediately.
- cfg_count  in  CNT_W  number of pulses per train.
- cfg_high  in  WID_W  base high width in cycles; 0 is treated as 1.
- cfg_low  in  WID_W  low width between pulses; 0 is treated as 1.
- cfg_jit_en  in  1  adds LFSR jitter to each high width.
- cfg_ch_mask  in  N_CH  enabled channels.
- cfg_mode  in  1  0 = broadcast to all enabled channels, 1 = round-robin.
- hit_out  out  N_CH  hit pulses, registered.
- busy  out  1  high from the cycle after start until the train ends.
- done  out  1  one-cycle pulse when a train completes normally.
- hits_sent  out  CNT_W  pulses emitted in the current or last train.

Behaviour:
- Reset values: hit_out=0, busy=0, done=0, hits_sent=0, state=IDLE, lfsr=LFSR_SEED, rr_ptr=0.
- All cfg_* inputs are sampled into shadow registers on an accepted start; changes during a train have no effect.
- States: IDLE, HIGH, LOW, FINISH.
- IDLE:
  - start=1 with cfg_count!=0 and cfg_ch_mask!=0 -> HIGH.
  - Next cycle: busy=1, hits_sent=0, hit_out driven (one-cycle latency).
  - start with cfg_count=0 or mask=0 -> FINISH; no pulses are emitted and done pulses.
- HIGH:
  - Lasts max(cfg_high,1)+jit cycles.
  - jit = lfsr[JIT_W-1:0], captured on entry when cfg_jit_en=1; otherwise jit=0.
  - Exit -> LOW; hit_out=0 and hits_sent increments on the same edge.
- LOW:
  - Lasts max(cfg_low,1) cycles.
  - Exit: hits_sent==count -> FINISH, else -> HIGH.
- FINISH: done=1 for exactly one cycle, busy=0, -> IDLE. The next start is accepted in the cycle after done.
- Channel drive:
  - Broadcast: hit_out = mask during HIGH.
  - Round-robin: hit_out = onehot(rr_ptr) during HIGH.
  - rr_ptr is loaded at start with the lowest set mask bit.
  - On each HIGH->LOW transition rr_ptr advances to the next set bit, wrapping from the MSB to the lowest set bit.
  - A single-bit mask repeats the same channel.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Steps every cycle while busy and holds in IDLE, so sequences are reproducible from the seed.
- Abort:
  - Any state -> IDLE on the next edge; hit_out=0 and busy=0 on that edge.
  - No done pulse; hits_sent holds its value.
  - abort has priority over start in the same cycle.
- Counter arithmetic:
  - Duration counters are WID_W+1 bits to hold high+jit without overflow.
  - hits_sent cannot wrap, because count<=2^CNT_W-1.
- Reset mid-train: everything returns to reset values asynchronously; hit_out drops with no glitch on its release.

Decomposition:
- Package hpg_pkg: state enum (IDLE, HIGH, LOW, FINISH), LFSR polynomial constant, default seed constant, and the next_set_bit function used for the round-robin pointer.
- Sub-module lfsr16: enable, seed parameter, 16-bit state output. Reused later for dither.

Test Plan:
- Broadcast, no jitter: count=32, high=20, low=30, mask=4'b1111, mode=0 -> 32 pulses per channel, each exactly 20 cycles high and 30 low; done pulses one cycle after the last LOW; hits_sent=32.
- Round-robin: count=6, mask=4'b1010 -> pulses alternate ch1, ch3, ch1, ch3, ch1, ch3; no other channel toggles.
- Jitter: jit_en=1, high=20, seed=16'hACE1 -> every high width is in 20..83; widths match the golden LFSR model cycle-for-cycle; after reset, a second run gives an identical sequence.
- Degenerate config: count=0 -> done within 2 cycles and no hit_out activity; high=0, low=0, count=3 -> 1-cycle high and 1-cycle low pulses.
- Abort in pulse 5, in HIGH -> hit_out=0 next cycle; busy=0; no done; hits_sent=4. Start asserted on the same cycle as abort is ignored.
- rst_n asserted mid-HIGH -> outputs go to 0 immediately; after release, a start yields a normal train.
